// File: rtl/debug_trace_pkg.sv
// -----------------------------------------------------------------------------
// debug_trace_pkg
// Shared types for the debug trace FIFO: the stored entry layout, the capture
// FSM state encoding and the drop-counter saturation helper.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a 16-bit timestamp field to
// every entry.
// -----------------------------------------------------------------------------
package debug_trace_pkg;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCEPT  = 2'd1,
        DISCARD = 2'd2
    } cap_state_e;

    typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
        logic [15:0] ts;
`endif
        logic        sop;
        logic [7:0]  ev;
        logic [31:0] tp;
    } trace_entry_t;

    // Saturating increment; holds at DROP_MAX instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == DROP_MAX) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debug_trace_ram.sv
// -----------------------------------------------------------------------------
// debug_trace_ram
// DEPTH x trace_entry_t storage: one synchronous write port, one asynchronous
// read port. No reset on the array; the FIFO top masks the head when empty.
// Ports:
//   clk      clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write entry
//   raddr_i  read address
//   rdata_o  read entry (combinational)
// Optional feature macro: TRACE_TIMESTAMP_EN (widens trace_entry_t).
// -----------------------------------------------------------------------------
module debug_trace_ram
    import debug_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  trace_entry_t      wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output trace_entry_t      rdata_o
);

    trace_entry_t mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/debug_trace_fifo.sv
// -----------------------------------------------------------------------------
// debug_trace_fifo
// Trace-packet buffer behind the per-IP debug wrappers. Frames TPE/TP/EV beats
// into packets (sop on TPE rising), stores them in a first-word-fall-through
// FIFO and drops whole packet tails on overflow without stalling the source.
// Ports:
//   clk       clock (rising edge)
//   MRST      asynchronous active-low reset
//   TPE/TP/EV trace beat valid / data / event code
//   flush     synchronous clear of FIFO, status and capture FSM
//   rd_rdy    consumer ready
//   rd_vld, rd_dat, rd_ev, rd_sop  head entry (zeros when empty)
//   count, full, empty             occupancy
//   ovf, drop_cnt                  sticky overflow flag, saturating drop count
//   rd_ts     head timestamp (only with TRACE_TIMESTAMP_EN)
// Optional feature macro: TRACE_TIMESTAMP_EN.
// -----------------------------------------------------------------------------
module debug_trace_fifo
    import debug_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          MRST,
    input  logic          TPE,
    input  logic [31:0]   TP,
    input  logic [7:0]    EV,
    input  logic          flush,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [31:0]   rd_dat,
    output logic [7:0]    rd_ev,
    output logic          rd_sop,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic [15:0]   drop_cnt
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [15:0]   rd_ts
`endif
);

    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

    cap_state_e     state_q;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic           tpe_prev_q;

    logic           full_s, empty_s, room_s;
    logic           push_s, pop_s, drop_s;
    trace_entry_t   wr_entry_s, rd_entry_s;

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == CNT_ZERO);

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts_q;

    // Free-running timestamp; survives flush, cleared only by MRST
    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            ts_q <= 16'd0;
        end else begin
            ts_q <= ts_q + 16'd1;
        end
    end
`endif

    // Push/pop/drop decode; flush suppresses all three
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        drop_s = 1'b0;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept
        room_s = !full_s || (!empty_s && rd_rdy);
        if (flush) begin
            pop_s = 1'b0;
        end else begin
            pop_s = !empty_s && rd_rdy;
            if (TPE) begin
                case (state_q)
                    DISCARD: drop_s = 1'b1;
                    default: begin
                        if (room_s) begin
                            push_s = 1'b1;
                        end else begin
                            drop_s = 1'b1;
                        end
                    end
                endcase
            end else begin
                push_s = 1'b0;
            end
        end
    end

    // Next-state for pointers, occupancy and overflow status
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            wr_ptr_d   = {AW{1'b0}};
            rd_ptr_d   = {AW{1'b0}};
            count_d    = CNT_ZERO;
            ovf_d      = 1'b0;
            drop_cnt_d = 16'd0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (drop_s) begin
                ovf_d      = 1'b1;
                drop_cnt_d = sat_inc16(drop_cnt_q);
            end else begin
                ovf_d      = ovf_q;
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // State registers and capture FSM
    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            state_q    <= IDLE;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= CNT_ZERO;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 16'd0;
            tpe_prev_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            // sop history tracks the wire even across flush
            tpe_prev_q <= TPE;
            if (flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (TPE) begin
                            state_q <= push_s ? ACCEPT : DISCARD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    ACCEPT: begin
                        if (!TPE) begin
                            state_q <= IDLE;
                        end else if (drop_s) begin
                            state_q <= DISCARD;
                        end else begin
                            state_q <= ACCEPT;
                        end
                    end
                    DISCARD: begin
                        if (!TPE) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DISCARD;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Entry assembly for the write port
    always_comb begin
        wr_entry_s     = '{default: 1'b0};
        wr_entry_s.sop = TPE && !tpe_prev_q;
        wr_entry_s.ev  = EV;
        wr_entry_s.tp  = TP;
`ifdef TRACE_TIMESTAMP_EN
        wr_entry_s.ts  = ts_q;
`endif
    end

    debug_trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry_s)
    );

    // Head presentation, forced to zero when the FIFO is empty
    always_comb begin
        rd_vld = !empty_s;
        if (empty_s) begin
            rd_dat = 32'd0;
            rd_ev  = 8'd0;
            rd_sop = 1'b0;
`ifdef TRACE_TIMESTAMP_EN
            rd_ts  = 16'd0;
`endif
        end else begin
            rd_dat = rd_entry_s.tp;
            rd_ev  = rd_entry_s.ev;
            rd_sop = rd_entry_s.sop;
`ifdef TRACE_TIMESTAMP_EN
            rd_ts  = rd_entry_s.ts;
`endif
        end
    end

    assign count    = count_q;
    assign full     = full_s;
    assign empty    = empty_s;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_debug_trace_fifo.sv
module tb_debug_trace_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        MRST = 1'b0;
    logic        TPE = 1'b0;
    logic [31:0] TP = 32'd0;
    logic [7:0]  EV = 8'd0;
    logic        flush = 1'b0;
    logic        rd_rdy = 1'b0;
    logic        rd_vld;
    logic [31:0] rd_dat;
    logic [7:0]  rd_ev;
    logic        rd_sop;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        ovf;
    logic [15:0] drop_cnt;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] rd_ts;
`endif

    debug_trace_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .MRST     (MRST),
        .TPE      (TPE),
        .TP       (TP),
        .EV       (EV),
        .flush    (flush),
        .rd_rdy   (rd_rdy),
        .rd_vld   (rd_vld),
        .rd_dat   (rd_dat),
        .rd_ev    (rd_ev),
        .rd_sop   (rd_sop),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
`ifdef TRACE_TIMESTAMP_EN
        ,
        .rd_ts    (rd_ts)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: packet-level behaviour expressed with a queue
    typedef struct {
        bit          sop;
        logic [7:0]  ev;
        logic [31:0] tp;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   m_drop;
    bit   m_tail_dropping;   // rest of current packet is being thrown away
    bit   m_prev;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_drop = 0;
        m_tail_dropping = 1'b0;
        m_prev = 1'b0;
    endtask

    task automatic model_cycle(input bit tpe, input logic [31:0] tp, input logic [7:0] ev,
                               input bit rdy, input bit fl);
        int sz;
        bit pop;
        bit sop;
        ent_t e;
        sz  = q.size();
        pop = (sz > 0) && rdy && !fl;
        sop = tpe && !m_prev;
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
            m_drop = 0;
            m_tail_dropping = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (tpe) begin
                if (!m_tail_dropping && (sz < DEPTH || pop)) begin
                    e.sop = sop; e.ev = ev; e.tp = tp;
                    q.push_back(e);
                end else begin
                    m_tail_dropping = 1'b1;
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end else begin
                m_tail_dropping = 1'b0;
            end
        end
        m_prev = tpe;
    endtask

    task automatic check_all();
        bit e;
        e = (q.size() == 0);
        chk("rd_vld",   rd_vld,   {31'd0, !e});
        chk("rd_dat",   rd_dat,   e ? 32'd0 : q[0].tp);
        chk("rd_ev",    rd_ev,    e ? 32'd0 : {24'd0, q[0].ev});
        chk("rd_sop",   rd_sop,   e ? 32'd0 : {31'd0, q[0].sop});
        chk("count",    count,    32'(q.size()));
        chk("full",     full,     {31'd0, q.size() == DEPTH});
        chk("empty",    empty,    {31'd0, e});
        chk("ovf",      ovf,      {31'd0, m_ovf});
        chk("drop_cnt", drop_cnt, 32'(m_drop));
`ifdef TRACE_TIMESTAMP_EN
        if (e) chk("rd_ts_empty", rd_ts, 32'd0);
`endif
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge
    task automatic step(input bit tpe, input logic [31:0] tp, input logic [7:0] ev,
                        input bit rdy, input bit fl, input bit do_chk);
        TPE = tpe; TP = tp; EV = ev; rd_rdy = rdy; flush = fl;
        model_cycle(tpe, tp, ev, rdy, fl);
        @(posedge clk);
        #1;
        if (do_chk) check_all();
    endtask

    logic [31:0] exp_tp [3];
    logic [7:0]  exp_ev [3];
    bit          exp_sop [3];
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] t0, t1;
`endif

    initial begin
        model_reset();
        exp_tp[0] = 32'hAAAA0001; exp_tp[1] = 32'hAAAA0002; exp_tp[2] = 32'hAAAA0003;
        exp_ev[0] = 8'h01;        exp_ev[1] = 8'h00;        exp_ev[2] = 8'h00;
        exp_sop[0] = 1'b1;        exp_sop[1] = 1'b0;        exp_sop[2] = 1'b0;

        // Reset state
        #3;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        MRST = 1'b1;
        check_all();

        // 3-beat burst, consumer stalled
        for (int i = 0; i < 3; i++) step(1'b1, exp_tp[i], exp_ev[i], 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("burst3_count", count, 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("burst3_dat", rd_dat, exp_tp[i]);
            chk("burst3_ev",  rd_ev,  {24'd0, exp_ev[i]});
            chk("burst3_sop", rd_sop, {31'd0, exp_sop[i]});
            step(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        end
        chk("burst3_empty", empty, 32'd1);

        // 20-beat burst into 16 slots
        for (int i = 0; i < 20; i++) step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0, 1'b1);
        chk("ovf20_count", count, 32'd16);
        chk("ovf20_full",  full,  32'd1);
        chk("ovf20_drop",  drop_cnt, 32'd4);
        chk("ovf20_ovf",   ovf,   32'd1);
        // Still discarding: pop frees a slot but the beat is dropped anyway
        step(1'b1, $urandom, 8'($urandom), 1'b1, 1'b0, 1'b1);
        chk("discard_drop", drop_cnt, 32'd5);
        chk("discard_count", count, 32'd15);
        step(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0, 1'b1);
        // Full + pop + push in one cycle
        step(1'b1, $urandom, 8'($urandom), 1'b1, 1'b0, 1'b1);
        chk("fullpp_count", count, 32'd16);
        chk("fullpp_drop",  drop_cnt, 32'd5);
        // Drop enters discard; 5 pops while the burst continues
        step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 8'($urandom), 1'b1, 1'b0, 1'b1);
        chk("pop5_count", count, 32'd11);
        chk("pop5_drop",  drop_cnt, 32'd11);
        step(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0, 1'b1);
        chk("newpkt_count", count, 32'd14);
        for (int i = 0; i < 15; i++) step(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);

        // Flush with ovf=1, drop_cnt=7, count=9
        step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 23; i++) step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        chk("preflush_count", count, 32'd9);
        chk("preflush_drop",  drop_cnt, 32'd7);
        step(1'b1, $urandom, 8'($urandom), 1'b1, 1'b1, 1'b1);
        chk("flush_count", count, 32'd0);
        chk("flush_empty", empty, 32'd1);
        chk("flush_ovf",   ovf,   32'd0);
        chk("flush_drop",  drop_cnt, 32'd0);
        step(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);

        // Saturation: 65540 drops after filling
        for (int i = 0; i < DEPTH + 65540; i++) step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0, 1'b0);
        check_all();
        chk("sat_drop", drop_cnt, 32'h0000FFFF);
        step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom, 8'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0), 1'b1);
        end
        step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1);

`ifdef TRACE_TIMESTAMP_EN
        // Beats pushed 10 cycles apart carry timestamps 10 apart
        step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0, 1'b1);
        t0 = rd_ts;
        for (int i = 0; i < 9; i++) step(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        t1 = rd_ts;
        chk("ts_delta", {16'd0, 16'(t1 - t0)}, 32'd10);
        step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1);
`endif

        // MRST mid-burst: immediate clear, first beat after release has sop
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0, 1'b1);
        #2;
        MRST = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        MRST = 1'b1;
        m_prev = 1'b0;
        step(1'b1, 32'h12345678, 8'h5A, 1'b0, 1'b0, 1'b1);
        chk("mrst_sop", rd_sop, 32'd1);
        chk("mrst_dat", rd_dat, 32'h12345678);
        step(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_trace_fifo.md
# debug_trace_fifo

Trace-packet buffer sitting directly downstream of the per-IP debug wrappers (SPI debug wrapper and siblings). Captures every beat presented on the wrapper's TP/TPE/EV outputs, frames beats into packets, and holds them in a first-word-fall-through FIFO. The trace consumer (security policy / trace-port controller) drains it with a valid/ready handshake. Overflow drops whole packet tails and is counted, never stalling the wrapper.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥4
- AW, 4, log2(DEPTH)

Ports:
- clk  in  1  single clock; all logic on rising edge
- MRST  in  1  reset, asynchronous, active-low
- TPE  in  1  trace beat valid from wrapper
- TP  in  32  trace beat data
- EV  in  8  event code aligned with TP
- flush  in  1  synchronous clear of FIFO and status
- rd_rdy  in  1  consumer ready
- rd_vld  out  1  head entry valid (= !empty)
- rd_dat  out  32  head TP
- rd_ev  out  8  head EV
- rd_sop  out  1  head is first beat of a packet
- count  out  AW+1  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- ovf  out  1  sticky: at least one beat dropped since reset/flush
- drop_cnt  out  16  dropped beats, saturating

## Operation
- Entry = {sop, EV, TP}; sop = TPE high this cycle and low previous cycle (registered TPE history, reset 0).
- Push = TPE && state==ACCEPT-eligible && (!full || pop). Pop = rd_vld && rd_rdy.
- Push and pop in same cycle: both occur, count unchanged; allowed when full (pop frees slot) and when empty is false.
- Pop when empty: impossible by definition (rd_vld=0); rd_rdy ignored.
- Pointers AW bits, wrap modulo DEPTH; count tracked separately in AW+1 bits.
- Capture FSM states:
  - IDLE: TPE low. On TPE: push if room → ACCEPT; else drop → DISCARD.
  - ACCEPT: TPE high, pushing. TPE low → IDLE. Beat with no room → drop, → DISCARD.
  - DISCARD: all beats dropped while TPE high, even if room appears. TPE low → IDLE.
- Every dropped beat: drop_cnt += 1 (hold at FFFF), ovf ← 1.
- flush: pointers, count, ovf, drop_cnt, FSM → reset values; beat present on TPE that cycle is neither pushed nor counted; sop history still updates. flush outranks push and pop.
- Reset values: rd_vld 0, rd_dat 0, rd_ev 0, rd_sop 0, count 0, full 0, empty 1, ovf 0, drop_cnt 0, FSM IDLE. Head outputs read 0 whenever empty.

## Timing
- Push at edge N → rd_vld/head data valid after edge N (visible cycle N+1); count, full, empty updated same edge.
- Pop at edge N → next entry on head outputs in cycle N+1.
- Zero-bubble: back-to-back TPE beats accepted every cycle while room; consumer may pop every cycle.
- MRST assertion mid-packet: immediate clear; first beat after release with TPE high gets sop=1.

## Configuration
- TRACE_TIMESTAMP_EN defined: 16-bit free-running cycle counter (reset 0, wraps FFFF→0); value latched into each entry at push; extra output port rd_ts (16) shows head timestamp, 0 when empty. flush does not clear the counter.
- Undefined: no counter, no rd_ts port, entry width 41 bits.

## Structure
- Shared package debug_trace_pkg: entry struct/typedef (sop, ev, tp, optional ts), capture FSM state enum (IDLE, ACCEPT, DISCARD), DROP_MAX = 16'hFFFF.
- One sub-module debug_trace_ram: DEPTH×entry storage, one synchronous write port, one asynchronous read port; pointers, count and FSM stay in the top.

## Test plan
- Reset, then 3-beat burst TP=AAAA0001/0002/0003, EV=01,00,00, rd_rdy=0 → count=3; drain gives sop=1,0,0 with same data/EV order.
- DEPTH=16, rd_rdy=0, 20-beat burst → 16 stored, full=1, drop_cnt=4, ovf=1; FSM in DISCARD until TPE falls.
- Full FIFO, rd_rdy=1 and TPE=1 same cycle → count stays 16, new beat stored, no drop.
- Full FIFO drop puts FSM in DISCARD; consumer pops 5 while burst continues → remaining beats still dropped; next burst after TPE low accepted with sop=1.
- Assert flush with ovf=1, drop_cnt=7, count=9 → next cycle count=0, empty=1, ovf=0, drop_cnt=0; 65540 drops without flush → drop_cnt=FFFF.
- With TRACE_TIMESTAMP_EN: beats pushed 10 cycles apart → rd_ts difference exactly 10; assert MRST mid-burst → all outputs at reset values next cycle.
